// File: rtl/pixel_wr_burst.sv
// Packs RGB565 pixels four to a 64-bit beat, buffers them and writes a frame as fixed-length bursts.
// Define PIXEL_WR_BURST_DROP_CNT_EN to add the saturating drop_cnt output.
`timescale 1ns/1ps
module pixel_wr_burst #(
    parameter int                BURST_LEN   = 16,
    parameter int                FIFO_DEPTH  = 64,
    parameter int                ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_BEATS = 196608
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [15:0]       wr_pixel,
    input  logic              wr_pixel_en,
    output logic              wr_burst_req,
    output logic [ADDR_W-1:0] wr_burst_addr,
    output logic [7:0]        wr_burst_len,
    input  logic              wr_burst_ack,
    output logic [63:0]       wr_data,
    output logic              wr_data_valid,
    input  logic              wr_data_ready,
    output logic              frame_done,
    output logic              overflow
`ifdef PIXEL_WR_BURST_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IB_W  = $clog2(FRAME_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_DATA
    } state_t;

    state_t             state;
    logic [1:0]         lane;
    logic [47:0]        pack;
    logic [63:0]        beat;
    logic               beat_pend;
    logic [63:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [IB_W-1:0]    issued_beats;
    logic [IB_W-1:0]    remaining;
    logic [7:0]         need;
    logic [7:0]         beat_cnt;
    logic               pix_take;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    // A frame_start cycle aborts everything in flight, so it suppresses pushes, pops and drops.
    assign pix_take  = wr_pixel_en && (state != S_IDLE || frame_start);
    assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop       = wr_data_valid && wr_data_ready && !frame_start;
    assign push      = beat_pend && (!full || pop) && !frame_start;
    assign drop      = beat_pend && full && !pop && !frame_start;
    assign remaining = IB_W'(FRAME_BEATS) - issued_beats;
    assign need      = (32'(remaining) < BURST_LEN) ? 8'(remaining) : 8'(BURST_LEN);
    assign wr_data   = wr_data_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane      <= 2'd0;
            pack      <= '0;
            beat      <= '0;
            beat_pend <= 1'b0;
        end else begin
            beat_pend <= 1'b0;
            if (frame_start) begin
                lane <= pix_take ? 2'd1 : 2'd0;
                if (pix_take) begin
                    pack[15:0] <= wr_pixel;
                end
            end else if (pix_take) begin
                if (lane == 2'd3) begin
                    beat      <= {wr_pixel, pack};
                    beat_pend <= 1'b1;
                    lane      <= 2'd0;
                end else begin
                    pack[16*lane +: 16] <= wr_pixel;
                    lane                <= lane + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (frame_start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (frame_start) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef PIXEL_WR_BURST_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (frame_start) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    // Data is only offered once the FIFO already holds the whole burst, so valid never stalls mid-burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_burst_req  <= 1'b0;
            wr_burst_addr <= '0;
            wr_burst_len  <= '0;
            wr_data_valid <= 1'b0;
            beat_cnt      <= '0;
            issued_beats  <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                state         <= S_WAIT;
                wr_burst_req  <= 1'b0;
                wr_data_valid <= 1'b0;
                beat_cnt      <= '0;
                issued_beats  <= '0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_WAIT: begin
                        if (need != 8'd0 && 32'(fifo_cnt) >= 32'(need)) begin
                            wr_burst_addr <= BASE_ADDR + (ADDR_W'(issued_beats) << 3);
                            wr_burst_len  <= need;
                            wr_burst_req  <= 1'b1;
                            state         <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (wr_burst_ack) begin
                            wr_burst_req  <= 1'b0;
                            beat_cnt      <= wr_burst_len;
                            wr_data_valid <= 1'b1;
                            state         <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (pop) begin
                            beat_cnt     <= beat_cnt - 8'd1;
                            issued_beats <= issued_beats + IB_W'(1);
                            if (beat_cnt == 8'd1) begin
                                wr_data_valid <= 1'b0;
                                if (issued_beats == IB_W'(FRAME_BEATS - 1)) begin
                                    frame_done <= 1'b1;
                                    state      <= S_IDLE;
                                end else begin
                                    state <= S_WAIT;
                                end
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pixel_wr_burst.md
Name: pixel_wr_burst

Overview:
- Downstream of the bilinear pixel filter; consumes its 16-bit RGB565 output stream (wr_pixel / wr_pixel_en).
- Packs 4 pixels into 64-bit beats and buffers them in an internal FIFO.
- Issues fixed-length write bursts with incrementing addresses to the frame-buffer memory controller, one frame at a time.

Parameters:
- BURST_LEN, 16, 64-bit beats per full burst (power of 2, 2..64)
- FIFO_DEPTH, 64, beat FIFO depth (power of 2, >= 2*BURST_LEN)
- ADDR_W, 28, byte-address width
- BASE_ADDR, 0, byte address of beat 0 of the frame
- FRAME_BEATS, 196608, beats per frame (1024x768 pixels / 4)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  one-cycle pulse; starts a new frame
- wr_pixel  in  16  RGB565 pixel from the filter
- wr_pixel_en  in  1  wr_pixel valid this cycle
- wr_burst_req  out  1  burst request to the memory controller
- wr_burst_addr  out  ADDR_W  burst start byte address
- wr_burst_len  out  8  beats in this burst
- wr_burst_ack  in  1  controller accepts the request (one-cycle pulse)
- wr_data  out  64  beat data
- wr_data_valid  out  1  wr_data valid
- wr_data_ready  in  1  controller consumes the beat when valid and ready
- frame_done  out  1  one-cycle pulse after the last beat of the frame is consumed
- overflow  out  1  sticky: a beat was dropped because the FIFO was full

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values: all outputs 0; FIFO empty; packer lane 0; beat counter 0; FSM IDLE.

Packer:
- Pixel k of each group of 4 goes to bits [16k+15:16k]; the first pixel lands in [15:0].
- The 4th pixel completes the beat, which is written to the FIFO on the next clock (1-cycle latency).
- If the FIFO is full when a beat completes, the beat is dropped and overflow is set. overflow clears only on rst or frame_start.

FIFO:
- First-word-fall-through; occupancy count 0..FIFO_DEPTH.
- Simultaneous write and read when full is allowed, because the read frees the slot.

Burst engine (FSM):
- need = min(BURST_LEN, FRAME_BEATS - issued_beats).
- IDLE: waits for frame_start, then goes to WAIT.
- WAIT: when FIFO count >= need, goes to REQ and latches wr_burst_addr = BASE_ADDR + issued_beats*8 and wr_burst_len = need.
- REQ: wr_burst_req = 1, with address and length held stable until wr_burst_ack. On ack: req drops the same cycle as the transition, state goes to DATA, beat_cnt = need.
- DATA: wr_data_valid = 1 whenever beat_cnt > 0; wr_data comes from the FIFO head. Each valid & ready handshake pops the FIFO, decrements beat_cnt and increments issued_beats. When beat_cnt reaches 0:
  - if issued_beats == FRAME_BEATS, pulse frame_done and go to IDLE;
  - otherwise go to WAIT.
- wr_data_valid never asserts outside DATA. Validity is guaranteed because the FIFO held at least need beats at request time.

Boundary conditions:
- frame_start in any state, including mid-burst, aborts the current frame: FIFO flushed, packer lane reset to 0 (partial beat discarded), issued_beats = 0, overflow cleared, req and valid deasserted the next cycle, FSM goes to WAIT. A pixel arriving in the same cycle as frame_start is the first pixel of the new frame.
- Pixels arriving in IDLE after frame_done are discarded and do not set overflow.
- The final burst is shorter when FRAME_BEATS is not a multiple of BURST_LEN.
- issued_beats width is ceil(log2(FRAME_BEATS+1)); address arithmetic is unsigned and wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: PIXEL_WR_BURST_DROP_CNT_EN.
- Defined: adds output port drop_cnt (16 bits), which counts dropped beats, saturates at 16'hFFFF, and clears on rst or frame_start. The overflow output is unchanged.
- Undefined: the port and its counter are absent; overflow alone reports drops.

Test Plan:
- Reset, then frame_start, then 64 consecutive pixels 16'h0001..16'h0040 with ready held 1 and ack returned 2 cycles after each req. Required: exactly one burst, addr = 0, len = 16; beat 0 = 64'h0004_0003_0002_0001; beat 15 = 64'h0040_003F_003E_003D.
- FRAME_BEATS = 20, 80 pixels. Required: two bursts, (addr 0, len 16) then (addr 128, len 4); one frame_done pulse after the 20th beat.
- wr_data_ready toggled 1,0,1,0 during DATA. Required: wr_data and wr_data_valid stay stable while ready = 0; exactly 16 beats in order; no beats lost or duplicated.
- wr_burst_ack withheld while 320 pixels stream in (FIFO_DEPTH = 64). Required: overflow = 1 after the 65th beat; FIFO holds beats 0..63; with the macro defined, drop_cnt = 16.
- frame_start asserted mid-burst after 5 beats consumed, with 2 pixels pending in the packer. Required: valid drops the next cycle; the next request has addr 0; the first beat of the new frame contains only new-frame pixels; overflow = 0.
- rst asserted asynchronously during REQ. Required: wr_burst_req = 0 immediately, without waiting for a clock edge; all outputs 0; after release, no activity until frame_start.
